aes_key_expand: RTL and testbench

//  AES-128 key schedule engine. Accepts a 128-bit cipher key and streams round keys 0..10 over a valid/ready handshake.

---
 rtl/aes_key_expand.sv | 185 ++++++++++++++++++
 tb/tb_aes_key_expand.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_expand : AES-128 key schedule, streams round keys 0..10 (ready/   |
// | valid). Optional KEY_EXP_STORE_EN adds an 11-entry round-key store.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   // Entry 0 sits in the most significant byte.
   localparam logic [2047:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = c_sbox[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand #(
   parameter int NR    = 10,
   parameter int IDX_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [127:0]      key_in,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [IDX_W-1:0]  rk_index,
   output logic [127:0]      rk_data,
   output logic              busy,
   output logic              done,
   input  logic [IDX_W-1:0]  rk_rd_idx,
   output logic [127:0]      rk_rd_data
);
   localparam logic [IDX_W-1:0] c_last = IDX_W'(NR);
   localparam logic [IDX_W-1:0] c_one  = IDX_W'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t             r_state;
   logic [127:0]       r_w;
   logic [IDX_W-1:0]   r_idx;
   logic               r_key_ready;
   logic               r_rk_valid;
   logic               r_busy;
   logic               r_done;

   logic               w_hs;
   logic [7:0]         w_rcon;
   logic [31:0]        w_rot;
   logic [31:0]        w_sub;
   logic [31:0]        w_t;
   logic [127:0]       w_next;

   assign w_hs = r_rk_valid & rk_ready;

   always_comb begin
      w_rcon = 8'h00;
      case (r_idx)
         4'd0:    w_rcon = 8'h01;
         4'd1:    w_rcon = 8'h02;
         4'd2:    w_rcon = 8'h04;
         4'd3:    w_rcon = 8'h08;
         4'd4:    w_rcon = 8'h10;
         4'd5:    w_rcon = 8'h20;
         4'd6:    w_rcon = 8'h40;
         4'd7:    w_rcon = 8'h80;
         4'd8:    w_rcon = 8'h1b;
         4'd9:    w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_rot = {r_w[23:0], r_w[31:24]};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .a (w_rot[8*gi +: 8]),
            .y (w_sub[8*gi +: 8])
         );
      end
   endgenerate

   assign w_t = w_sub ^ {w_rcon, 24'h0};

   // Each output word chains off the previous new word.
   always_comb begin
      w_next[127:96] = r_w[127:96] ^ w_t;
      w_next[95:64]  = r_w[95:64]  ^ w_next[127:96];
      w_next[63:32]  = r_w[63:32]  ^ w_next[95:64];
      w_next[31:0]   = r_w[31:0]   ^ w_next[63:32];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_w         <= '0;
         r_idx       <= '0;
         r_key_ready <= 1'b1;
         r_rk_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (key_valid && r_key_ready) begin
                  r_w         <= key_in;
                  r_idx       <= '0;
                  r_state     <= EMIT;
                  r_key_ready <= 1'b0;
                  r_rk_valid  <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            EMIT: begin
               if (w_hs) begin
                  if (r_idx == c_last) begin
                     r_state     <= IDLE;
                     r_key_ready <= 1'b1;
                     r_rk_valid  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_w   <= w_next;
                     r_idx <= r_idx + c_one;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign key_ready = r_key_ready;
   assign rk_valid  = r_rk_valid;
   assign rk_index  = r_idx;
   assign rk_data   = r_w;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef KEY_EXP_STORE_EN
   logic [127:0] r_store [0:NR];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) begin
            r_store[i] <= '0;
         end
      end else if (w_hs && (r_state == EMIT)) begin
         r_store[r_idx] <= r_w;
      end
   end

   assign rk_rd_data = (rk_rd_idx <= c_last) ? r_store[rk_rd_idx] : 128'h0;
`else
   logic w_unused_rd_idx;
   assign w_unused_rd_idx = ^rk_rd_idx;
   assign rk_rd_data      = 128'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// Scoreboard bench for aes_key_expand: directed FIPS-197 and zero-key vectors.
module tb_aes_key_expand;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [127:0] key_in = '0;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic [3:0]   rk_index;
   logic [127:0] rk_data;
   logic         busy;
   logic         done;
   logic [3:0]   rk_rd_idx = '0;
   logic [127:0] rk_rd_data;

   aes_key_expand #(.NR(10), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
      .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready),
      .rk_index(rk_index), .rk_data(rk_data), .busy(busy), .done(done),
      .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] data;
      bit           chk;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           fails = 0;
   int           done_cnt = 0;
   bit           mon_en = 1'b0;
   bit           done_exp = 1'b0;
   bit           stall = 1'b0;
   logic [127:0] stall_data;
   logic [3:0]   stall_idx;

   logic [127:0] fips_rk [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   logic [127:0] zero_rk1  = 128'h62636363626363636263636362636363;
   logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from input changes.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            done_exp = 1'b0;
            stall    = 1'b0;
         end else begin
            check("done", 128'(done), 128'(done_exp));
            if (done) done_cnt++;
            if (done_exp) begin
               check("done_key_ready", 128'(key_ready), 128'h1);
               check("done_rk_valid", 128'(rk_valid), 128'h0);
            end
            done_exp = 1'b0;
            if (stall) begin
               check("stall_valid", 128'(rk_valid), 128'h1);
               check("stall_data", rk_data, stall_data);
               check("stall_idx", 128'(rk_index), 128'(stall_idx));
            end
            stall = rk_valid && !rk_ready;
            stall_data = rk_data;
            stall_idx  = rk_index;
            if (rk_valid) check("emit_key_ready", 128'(key_ready), 128'h0);
            if (rk_valid && rk_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_rk actual idx=%0d data=%h required=none", rk_index, rk_data);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("rk_index", 128'(rk_index), 128'(e.idx));
                  if (e.chk) check("rk_data", rk_data, e.data);
                  if (rk_index == 4'd10) done_exp = 1'b1;
               end
            end
         end
      end
   end

   // kind 0: FIPS key (all keys known), kind 1: zero key (rk0, rk1, rk10 known).
   task automatic load_key(input logic [127:0] key, input int kind);
      int n = 0;
      while (!key_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("key_ready_wait", 128'(key_ready), 128'h1);
      for (int i = 0; i <= 10; i++) begin
         exp_t e;
         e.idx = 4'(i);
         if (kind == 0) begin
            e.data = fips_rk[i];
            e.chk  = 1'b1;
         end else begin
            e.data = (i == 0) ? key : ((i == 1) ? zero_rk1 : zero_rk10);
            e.chk  = (i == 0 || i == 1 || i == 10);
         end
         sb.push_back(e);
      end
      key_in    = key;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("first_valid", 128'(rk_valid), 128'h1);
      check("first_idx", 128'(rk_index), 128'h0);
   endtask

   // mode 0: rk_ready held high; mode 1: ~30% ready with stray key_valid pulses.
   task automatic run_stream(input int mode, input int d0);
      int n = 0;
      while (done_cnt <= d0 && n < 500) begin
         if (mode == 0) begin
            rk_ready = 1'b1;
         end else begin
            rk_ready  = ($urandom_range(0, 99) < 30);
            key_valid = busy && ($urandom_range(0, 3) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk); #1;
         key_valid = 1'b0;
         n++;
      end
      if (done_cnt <= d0) begin
         checks++;
         fails++;
         $display("FAIL stream_timeout actual done_cnt=%0d required>%0d", done_cnt, d0);
      end
      rk_ready = 1'b1;
   endtask

   initial begin
      int d0;
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_key_ready", 128'(key_ready), 128'h1);
      check("rst_rk_valid", 128'(rk_valid), 128'h0);
      check("rst_done", 128'(done), 128'h0);
      check("rst_busy", 128'(busy), 128'h0);
      check("rst_rk_data", rk_data, 128'h0);
      check("rst_rk_index", 128'(rk_index), 128'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 key, ready held high: 11 transfers then done.
      rk_ready = 1'b1;
      d0 = done_cnt;
      load_key(fips_rk[0], 0);
      repeat (11) begin
         @(posedge clk); #1;
      end
      check("fips_done_at_11", 128'(done), 128'h1);
      check("fips_idle_busy", 128'(busy), 128'h0);
      run_stream(0, d0);

      rk_rd_idx = 4'd1;
      #1;
`ifdef KEY_EXP_STORE_EN
      check("store_rd1", rk_rd_data, fips_rk[1]);
      rk_rd_idx = 4'd10;
      #1;
      check("store_rd10", rk_rd_data, fips_rk[10]);
`else
      check("nostore_rd1", rk_rd_data, 128'h0);
`endif
      rk_rd_idx = 4'd15;
      #1;
      check("store_rd15", rk_rd_data, 128'h0);

      // Zero key.
      d0 = done_cnt;
      load_key(128'h0, 1);
      run_stream(0, d0);

      // Backpressure with ignored key_valid pulses.
      d0 = done_cnt;
      load_key(fips_rk[0], 0);
      run_stream(1, d0);

      // Reset mid-stream at index 5, then a clean zero-key stream.
      rk_ready = 1'b1;
      load_key(fips_rk[0], 0);
      n = 0;
      while (rk_index != 4'd5 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_idx5", 128'(rk_index), 128'h5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      check("mid_rst_valid", 128'(rk_valid), 128'h0);
      check("mid_rst_ready", 128'(key_ready), 128'h1);
      check("mid_rst_busy", 128'(busy), 128'h0);
      check("mid_rst_index", 128'(rk_index), 128'h0);
      check("mid_rst_data", rk_data, 128'h0);
      d0 = done_cnt;
      load_key(128'h0, 1);
      run_stream(0, d0);

      // Reset wins over a simultaneous key_valid.
      rst = 1'b1;
      key_valid = 1'b1;
      key_in = fips_rk[0];
      @(posedge clk); #1;
      rst = 1'b0;
      key_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_wins_valid", 128'(rk_valid), 128'h0);
      check("rst_wins_data", rk_data, 128'h0);

      check("sb_empty", 128'(sb.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire
